// File: rtl/seq_det_ctrl_if.sv
// Byte-stream and frame-report handshakes for seq_det_ctrl.
// The master modport is the producer/consumer side; the slave modport is the controller.
interface seq_det_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  m_count;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_count
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_count
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Frame-scoped programmable pattern detector: serializes bytes MSB-first, counts
// matches across a frame and reports the saturating count over a handshake.
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  output logic             match,
  output logic             busy,
  seq_det_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_e;

  localparam int BC_W   = $clog2(DATA_W + 1);
  localparam int FILL_W = $clog2(PAT_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              busy_q, busy_d;

  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_next;
  logic              hit;

  // Candidate history/fill after consuming the current MSB, shared by SHIFT.
  always_comb begin
    hist_next = {hist_q[PAT_W-2:0], data_q[DATA_W-1]};
    fill_next = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    hit       = (fill_next == FILL_W'(PAT_W)) && (hist_next == pat_q);
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    match_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          data_d    = bus.s_data;
          last_d    = bus.s_last;
          bit_cnt_d = BC_W'(DATA_W);
          state_d   = SHIFT;
          // Configuration is frozen for the whole frame at its first byte.
          if (!busy_q) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            busy_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        data_d    = {data_q[DATA_W-2:0], 1'b0};
        hist_d    = hist_next;
        fill_d    = fill_next;
        bit_cnt_d = bit_cnt_q - BC_W'(1);
        if (hit) begin
          match_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (!ovl_q) fill_d = '0;
        end
        if (bit_cnt_q == BC_W'(1)) state_d = last_q ? REPORT : IDLE;
      end
      REPORT: begin
        if (bus.m_ready) begin
          cnt_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_ready = (state_q == IDLE);
  assign bus.m_valid = (state_q == REPORT);
  assign bus.m_count = cnt_q;
  assign match       = match_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed frames plus randomized frames,
// compared against a window-scan reference model of the frame's bit stream.
module tb_seq_det_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 3;
  localparam int CNT_W  = 8;

  logic             clk;
  logic             rst;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             match;
  logic             busy;

  seq_det_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  seq_det_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .match       (match),
    .busy        (busy),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] frame_bytes[$];
  bit         frame_bits[$];
  bit         exp_hit[$];
  int         exp_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a match ends at bit i when the last PAT_W bits equal the pattern
  // and (non-overlap only) none of those bits belong to an earlier match.
  task automatic model(input logic [PAT_W-1:0] pat, input bit ovl);
    int last_end = 0;
    frame_bits.delete();
    exp_hit.delete();
    exp_count = 0;
    foreach (frame_bytes[b])
      for (int k = DATA_W - 1; k >= 0; k--) frame_bits.push_back(frame_bytes[b][k]);
    for (int i = 1; i <= frame_bits.size(); i++) begin
      bit hit = (i - last_end >= PAT_W);
      if (hit)
        for (int j = 0; j < PAT_W; j++)
          if (frame_bits[i-1-j] != pat[j]) hit = 0;
      exp_hit.push_back(hit);
      if (hit) begin
        if (exp_count < (1 << CNT_W) - 1) exp_count++;
        if (!ovl) last_end = i;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("s_ready_timeout", 0, 1);
  endtask

  // Drives one frame from frame_bytes and checks every match pulse, s_ready during
  // shifting, the report and its backpressure; want >= 0 adds a fixed-count check.
  task automatic run_frame(input logic [PAT_W-1:0] pat, input bit ovl, input int hold,
                           input bit cfg_chg, input int want);
    int bit_idx = 0;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    model(pat, ovl);
    for (int b = 0; b < frame_bytes.size(); b++) begin
      wait_ready();
      bus.s_valid = 1'b1;
      bus.s_data  = frame_bytes[b];
      bus.s_last  = (b == frame_bytes.size() - 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      if (b == 0) check("busy_open", busy, 1);
      if (cfg_chg && b == 0) begin
        cfg_pattern = ~pat;
        cfg_overlap = ~ovl;
      end
      for (int k = 1; k <= DATA_W; k++) begin
        check("s_ready_shift", bus.s_ready, 0);
        @(posedge clk); #1;
        check("match_bit", match, exp_hit[bit_idx]);
        bit_idx++;
      end
      if (b != frame_bytes.size() - 1) check("s_ready_back", bus.s_ready, 1);
    end
    check("m_valid_up", bus.m_valid, 1);
    check("m_count", bus.m_count, exp_count);
    if (want >= 0) check("m_count_fixed", bus.m_count, want);
    for (int h = 0; h < hold; h++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      bus.s_last  = 1'b1;
      @(posedge clk); #1;
      check("hold_m_valid", bus.m_valid, 1);
      check("hold_m_count", bus.m_count, exp_count);
      check("hold_s_ready", bus.s_ready, 0);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    check("post_m_valid", bus.m_valid, 0);
    check("post_s_ready", bus.s_ready, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_match", match, 0);
    check("rst_busy", busy, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_count", bus.m_count, 0);

    // Overlap and non-overlap on 0xAA with pattern 101.
    frame_bytes = '{8'hAA};
    run_frame(3'b101, 1'b1, 0, 1'b0, 3);
    run_frame(3'b101, 1'b0, 0, 1'b0, 2);

    // History carries across the byte boundary.
    frame_bytes = '{8'h01, 8'h80};
    run_frame(3'b110, 1'b1, 0, 1'b0, 1);

    // Saturation at 2^CNT_W-1.
    frame_bytes.delete();
    repeat (32) frame_bytes.push_back(8'h00);
    run_frame(3'b000, 1'b1, 0, 1'b0, 254);
    frame_bytes.push_back(8'h00);
    run_frame(3'b000, 1'b1, 0, 1'b0, 255);

    // Report backpressure with s_valid driven, plus mid-frame config change.
    frame_bytes = '{8'hAA, 8'h55};
    run_frame(3'b101, 1'b1, 5, 1'b1, 6);

    // Reset while shifting 0xAA, then a clean frame.
    cfg_pattern = 3'b101;
    cfg_overlap = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    bus.s_last  = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_match", match, 0);
    frame_bytes = '{8'hAA};
    run_frame(3'b101, 1'b1, 0, 1'b0, 3);

    // Randomized frames against the reference model.
    repeat (8) begin
      int len;
      len = $urandom_range(1, 4);
      frame_bytes.delete();
      for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
      run_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
